// File: rtl/pc_redirect_ctrl_if.sv
// pc_redirect_ctrl_if: PC redirect request/response bundle between the core and the redirect controller.
interface pc_redirect_ctrl_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
);
    logic             ex_valid;
    logic             ex_pcsel;
    logic [XLEN-1:0]  ex_target;
    logic             trap_req;
    logic [XLEN-1:0]  trap_vector;
    logic             stall_req;
    logic             imem_ready;
    logic             pc_we;
    logic [1:0]       pc_next_sel;
    logic [XLEN-1:0]  pc_redirect;
    logic             flush_if_id;
    logic             flush_id_ex;
    logic             redirect_pending;
    logic [CNT_W-1:0] redirect_count;

    modport master (
        output ex_valid, ex_pcsel, ex_target, trap_req, trap_vector, stall_req, imem_ready,
        input  pc_we, pc_next_sel, pc_redirect, flush_if_id, flush_id_ex, redirect_pending, redirect_count
    );

    modport slave (
        input  ex_valid, ex_pcsel, ex_target, trap_req, trap_vector, stall_req, imem_ready,
        output pc_we, pc_next_sel, pc_redirect, flush_if_id, flush_id_ex, redirect_pending, redirect_count
    );
endinterface

// File: rtl/pc_redirect_ctrl.sv
// pc_redirect_ctrl: sequences PC redirects and pipeline squashes, holding across imem back-pressure.
module pc_redirect_ctrl #(
    parameter int XLEN         = 32,
    parameter int DRAIN_CYCLES = 1,
    parameter int CNT_W        = 16
) (
    input logic              clock,
    input logic              reset,
    pc_redirect_ctrl_if.slave bus
);
    typedef enum logic [1:0] {RUN, HOLD, DRAIN} state_t;
    localparam logic [2:0] DRAIN_INIT = 3'(DRAIN_CYCLES);
    localparam state_t AFTER = (DRAIN_CYCLES == 0) ? RUN : DRAIN;

    state_t           state, state_n;
    logic [XLEN-1:0]  held_tgt, held_tgt_n, ev_tgt, red;
    logic [1:0]       held_sel, held_sel_n, ev_sel, sel;
    logic [2:0]       drain_cnt, drain_cnt_n;
    logic [CNT_W-1:0] cnt;
    logic             ev, we, fif, fie, pend;

    always_comb begin
        ev          = bus.trap_req | (state == RUN & bus.ex_valid & bus.ex_pcsel);
        ev_sel      = bus.trap_req ? 2'b10 : 2'b01;
        ev_tgt      = bus.trap_req ? bus.trap_vector : {bus.ex_target[XLEN-1:1], 1'b0};
        state_n     = state;
        held_tgt_n  = held_tgt;
        held_sel_n  = held_sel;
        drain_cnt_n = drain_cnt;
        we          = 1'b0;
        sel         = 2'b00;
        red         = '0;
        fif         = 1'b0;
        fie         = 1'b0;
        pend        = 1'b0;
        if (ev || state == HOLD) begin
            // a fresh event (including a trap arriving in HOLD) replaces the held redirect
            held_tgt_n  = ev ? ev_tgt : held_tgt;
            held_sel_n  = ev ? ev_sel : held_sel;
            sel         = held_sel_n;
            red         = held_tgt_n;
            fif         = 1'b1;
            fie         = 1'b1;
            we          = bus.imem_ready;
            pend        = state == HOLD & ~bus.imem_ready;
            state_n     = bus.imem_ready ? AFTER : HOLD;
            drain_cnt_n = DRAIN_INIT;
        end else if (state == DRAIN) begin
            fif = 1'b1;
            we  = bus.imem_ready & ~bus.stall_req;
            if (bus.imem_ready) begin
                drain_cnt_n = drain_cnt - 3'd1;
                state_n     = (drain_cnt <= 3'd1) ? RUN : DRAIN;
            end
        end else begin
            we      = bus.imem_ready & ~bus.stall_req;
            fie     = bus.stall_req;
            state_n = RUN;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= RUN;
            held_tgt  <= '0;
            held_sel  <= 2'b00;
            drain_cnt <= 3'd0;
            cnt       <= '0;
        end else begin
            state     <= state_n;
            held_tgt  <= held_tgt_n;
            held_sel  <= held_sel_n;
            drain_cnt <= drain_cnt_n;
            if (we && sel != 2'b00) cnt <= cnt + 1'b1;
        end
    end

    assign bus.pc_we            = ~reset & we;
    assign bus.pc_next_sel      = reset ? 2'b00 : sel;
    assign bus.pc_redirect      = reset ? '0 : red;
    assign bus.flush_if_id      = ~reset & fif;
    assign bus.flush_id_ex      = ~reset & fie;
    assign bus.redirect_pending = ~reset & pend;
    assign bus.redirect_count   = reset ? '0 : cnt;
endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// tb_pc_redirect_ctrl: directed scoreboard bench for pc_redirect_ctrl (two parameterisations).
module tb_pc_redirect_ctrl;
    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    pc_redirect_ctrl_if #(.XLEN(32), .CNT_W(16)) ia ();
    pc_redirect_ctrl_if #(.XLEN(32), .CNT_W(4))  ib ();

    pc_redirect_ctrl #(.XLEN(32), .DRAIN_CYCLES(1), .CNT_W(16)) dut_a (
        .clock(clock), .reset(reset), .bus(ia.slave)
    );
    pc_redirect_ctrl #(.XLEN(32), .DRAIN_CYCLES(3), .CNT_W(4)) dut_b (
        .clock(clock), .reset(reset), .bus(ib.slave)
    );

    typedef struct {
        string       name;
        int          d;
        logic [5:0]  ctl;
        logic [31:0] red;
        logic [15:0] cnt;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic drv(input int d, input logic v, input logic p, input logic [31:0] tgt,
                       input logic t, input logic [31:0] tv, input logic s, input logic r);
        if (d == 0) begin
            ia.ex_valid = v; ia.ex_pcsel = p; ia.ex_target = tgt;
            ia.trap_req = t; ia.trap_vector = tv; ia.stall_req = s; ia.imem_ready = r;
        end else begin
            ib.ex_valid = v; ib.ex_pcsel = p; ib.ex_target = tgt;
            ib.trap_req = t; ib.trap_vector = tv; ib.stall_req = s; ib.imem_ready = r;
        end
    endtask

    task automatic expect_out(input string n, input int d, input logic we, input logic [1:0] sel,
                              input logic fif, input logic fie, input logic pend,
                              input logic [31:0] red, input logic [15:0] cnt);
        exp_t e;
        e.name = n; e.d = d; e.ctl = {we, sel, fif, fie, pend}; e.red = red; e.cnt = cnt;
        q.push_back(e);
    endtask

    task automatic cyc;
        @(posedge clock);
        #1;
    endtask

    // monitor: outputs are combinational, so compare mid-cycle on the falling edge
    always @(negedge clock) begin
        if (q.size() > 0) begin
            exp_t        e;
            logic [5:0]  a_ctl;
            logic [31:0] a_red;
            logic [15:0] a_cnt;
            e = q.pop_front();
            if (e.d == 0) begin
                a_ctl = {ia.pc_we, ia.pc_next_sel, ia.flush_if_id, ia.flush_id_ex, ia.redirect_pending};
                a_red = ia.pc_redirect;
                a_cnt = ia.redirect_count;
            end else begin
                a_ctl = {ib.pc_we, ib.pc_next_sel, ib.flush_if_id, ib.flush_id_ex, ib.redirect_pending};
                a_red = ib.pc_redirect;
                a_cnt = 16'(ib.redirect_count);
            end
            n_cmp++;
            if (a_ctl !== e.ctl || a_cnt !== e.cnt || (e.ctl[4:3] != 2'b00 && a_red !== e.red)) begin
                n_bad++;
                $display("FAIL %s: got we/sel/fif/fie/pend=%b red=%h cnt=%0d, want %b red=%h cnt=%0d",
                         e.name, a_ctl, a_red, a_cnt, e.ctl, e.red, e.cnt);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end

    initial begin
        drv(0, 1, 1, 32'h100, 1, 32'h8000_0000, 0, 1);
        drv(1, 0, 0, 0, 0, 0, 0, 0);
        cyc(); expect_out("reset_a0", 0, 0, 2'b00, 0, 0, 0, 0, 0);
        cyc(); expect_out("reset_a1", 0, 0, 2'b00, 0, 0, 0, 0, 0);
        cyc(); reset = 1'b0;
        drv(0, 0, 0, 0, 0, 0, 0, 1);           expect_out("run_idle", 0, 1, 2'b00, 0, 0, 0, 0, 0);
        cyc(); drv(0, 1, 1, 32'h1235, 0, 0, 0, 1); expect_out("br_align", 0, 1, 2'b01, 1, 1, 0, 32'h1234, 0);
        cyc(); drv(0, 0, 0, 0, 0, 0, 0, 1);    expect_out("drain1", 0, 1, 2'b00, 1, 0, 0, 0, 1);
        cyc(); drv(0, 0, 0, 0, 0, 0, 0, 1);    expect_out("run_after_drain", 0, 1, 2'b00, 0, 0, 0, 0, 1);
        cyc(); drv(0, 1, 1, 32'h2000, 0, 0, 0, 0); expect_out("br_not_ready", 0, 0, 2'b01, 1, 1, 0, 32'h2000, 1);
        for (int i = 0; i < 3; i++) begin
            cyc(); drv(0, 1, 1, 32'h3000, 0, 0, 0, 0);
            expect_out($sformatf("hold%0d", i), 0, 0, 2'b01, 1, 1, 1, 32'h2000, 1);
        end
        cyc(); drv(0, 0, 0, 0, 0, 0, 0, 1);    expect_out("hold_release", 0, 1, 2'b01, 1, 1, 0, 32'h2000, 1);
        cyc(); drv(0, 0, 0, 0, 0, 0, 0, 1);    expect_out("drain_after_hold", 0, 1, 2'b00, 1, 0, 0, 0, 2);
        cyc(); drv(0, 1, 1, 32'h2000, 0, 0, 0, 0); expect_out("br_hold2", 0, 0, 2'b01, 1, 1, 0, 32'h2000, 2);
        cyc(); drv(0, 0, 0, 0, 1, 32'h8000_0000, 0, 0); expect_out("hold_trap", 0, 0, 2'b10, 1, 1, 1, 32'h8000_0000, 2);
        cyc(); drv(0, 0, 0, 0, 0, 0, 0, 1);    expect_out("hold_trap_rel", 0, 1, 2'b10, 1, 1, 0, 32'h8000_0000, 2);
        cyc(); drv(0, 0, 0, 0, 0, 0, 0, 1);    expect_out("cnt_plus_one", 0, 1, 2'b00, 1, 0, 0, 0, 3);
        cyc(); drv(0, 1, 1, 32'h100, 1, 32'h8000_0000, 0, 1); expect_out("trap_prio", 0, 1, 2'b10, 1, 1, 0, 32'h8000_0000, 3);
        cyc(); drv(0, 0, 0, 0, 0, 0, 0, 1);    expect_out("drain_trap", 0, 1, 2'b00, 1, 0, 0, 0, 4);
        cyc(); drv(0, 0, 0, 0, 0, 0, 1, 1);    expect_out("stall", 0, 0, 2'b00, 0, 1, 0, 0, 4);
        cyc(); drv(0, 1, 1, 32'h40, 0, 0, 1, 1); expect_out("stall_vs_br", 0, 1, 2'b01, 1, 1, 0, 32'h40, 4);
        cyc(); drv(0, 0, 0, 0, 0, 0, 1, 1);    expect_out("drain_stall", 0, 0, 2'b00, 1, 0, 0, 0, 5);
        cyc(); drv(0, 0, 0, 0, 0, 0, 0, 1);    expect_out("run_idle2", 0, 1, 2'b00, 0, 0, 0, 0, 5);
        cyc(); drv(0, 1, 1, 32'h500, 0, 0, 0, 1); expect_out("br_500", 0, 1, 2'b01, 1, 1, 0, 32'h500, 5);
        cyc(); drv(0, 0, 0, 0, 1, 32'h1000, 0, 1); expect_out("drain_trap_ev", 0, 1, 2'b10, 1, 1, 0, 32'h1000, 6);
        cyc(); drv(0, 1, 1, 32'h700, 0, 0, 0, 1); expect_out("drain_br_ignored", 0, 1, 2'b00, 1, 0, 0, 0, 7);
        cyc(); drv(0, 0, 0, 0, 0, 0, 0, 1);    expect_out("run_idle3", 0, 1, 2'b00, 0, 0, 0, 0, 7);
        cyc(); drv(0, 1, 1, 32'h900, 0, 0, 0, 0); expect_out("br_to_hold", 0, 0, 2'b01, 1, 1, 0, 32'h900, 7);
        cyc(); reset = 1'b1; drv(0, 0, 0, 0, 0, 0, 0, 1); expect_out("reset_mid_hold", 0, 0, 2'b00, 0, 0, 0, 0, 0);
        cyc(); reset = 1'b0; drv(0, 0, 0, 0, 0, 0, 0, 1); expect_out("run_after_reset", 0, 1, 2'b00, 0, 0, 0, 0, 0);
        cyc(); drv(0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 17; i++) begin
            drv(1, 0, 0, 0, 1, 32'h100 + 32'(i * 4), 0, 1);
            expect_out($sformatf("wrap%0d", i), 1, 1, 2'b10, 1, 1, 0, 32'h100 + 32'(i * 4), 16'(i % 16));
            cyc();
        end
        for (int i = 0; i < 5; i++) begin
            drv(1, 0, 0, 0, 0, 0, 0, logic'(i % 2 == 0));
            expect_out($sformatf("drain3_%0d", i), 1, logic'(i % 2 == 0), 2'b00, 1, 0, 0, 0, 1);
            cyc();
        end
        drv(1, 0, 0, 0, 0, 0, 0, 1);
        expect_out("drain3_done", 1, 1, 2'b00, 0, 0, 0, 0, 1);
        cyc();
        @(negedge clock);
        #1;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL drain_queue: %0d expectations left unchecked, want 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/pc_redirect_ctrl.md
Name: pc_redirect_ctrl

Overview:
- Sequences PC updates and pipeline squashes for the RV32 core.
- Consumes the EX-stage branch/jump decision (pcsel), trap requests, the load-use stall and the instruction-memory ready signal.
- Drives the PC mux select, the PC write enable and the IF/ID and ID/EX flush signals.
- Holds a redirect across instruction-memory back-pressure, and drains wrong-path fetches that return after the redirect.

Parameters:
- XLEN, 32, address width of the PC and targets.
- DRAIN_CYCLES, 1, number of imem_ready cycles after a redirect during which IF/ID stays flushed (range 0..7).
- CNT_W, 16, width of the redirect event counter.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- ex_valid  in  1  EX stage holds a real instruction.
- ex_pcsel  in  1  EX branch taken, or jal/jalr.
- ex_target  in  XLEN  EX computed target.
- trap_req  in  1  trap/exception redirect request (level).
- trap_vector  in  XLEN  trap handler address.
- stall_req  in  1  load-use hazard stall request.
- imem_ready  in  1  fetch accepts a new PC this cycle.
- pc_we  out  1  PC register write enable.
- pc_next_sel  out  2  00 = PC+4, 01 = branch/jump target, 10 = trap vector.
- pc_redirect  out  XLEN  redirect address presented to the PC mux.
- flush_if_id  out  1  squash the IF/ID register.
- flush_id_ex  out  1  squash the ID/EX register (bubble insert).
- redirect_pending  out  1  a redirect is captured but not yet written to the PC.
- redirect_count  out  CNT_W  number of redirects written to the PC.

Behaviour:

Reset and state register
- Reset is synchronous; while reset is high, all outputs are 0.
- Reset state: state = RUN, held target = 0, drain counter = 0, redirect_count = 0.
- Reset mid-HOLD or mid-DRAIN abandons the operation; the next cycle is RUN with no pending redirect.
- States: RUN, HOLD, DRAIN (2-bit register).
- All outputs are combinational from state, held registers and inputs, except redirect_count, which is registered.

Redirect source and priority
- Priority: trap_req > (ex_valid & ex_pcsel) > sequential.
- Branch target is aligned as {ex_target[XLEN-1:1],1'b0}; trap_vector is used unmodified.
- A redirect event is a trap in RUN/HOLD/DRAIN, or a branch in RUN only.
- Each redirect event loads the held target and source.

RUN
- No event: pc_next_sel = 00; pc_we = imem_ready & ~stall_req; flush_if_id = 0; flush_id_ex = stall_req.
- Event, zero latency: flush_if_id = flush_id_ex = 1; pc_redirect = selected target; pc_next_sel = source code.
- If imem_ready on the event cycle: pc_we = 1. Next state is DRAIN with counter = DRAIN_CYCLES, or RUN if DRAIN_CYCLES = 0.
- If not imem_ready: pc_we = 0; next state is HOLD.
- stall_req is ignored on a redirect cycle; the redirect wins.

HOLD
- redirect_pending = 1; both flushes = 1; pc_redirect and pc_next_sel come from the held registers.
- ex_pcsel is ignored, since EX is already squashed.
- A new trap_req overwrites the held target with the trap vector (code 10) in the same cycle.
- When imem_ready: pc_we = 1; transition as in RUN.

DRAIN
- flush_if_id = 1; flush_id_ex = 0; pc_next_sel = 00; pc_we = imem_ready & ~stall_req.
- The counter decrements on each imem_ready cycle; DRAIN returns to RUN on the cycle the counter reaches 1 and imem_ready is high.
- ex_pcsel is ignored.
- trap_req is treated exactly as a RUN event, and the drain counter is reloaded.

Counter
- redirect_count increments on every cycle with pc_we = 1 and pc_next_sel != 00.
- Wraps modulo 2^CNT_W.

Invariants
- pc_we and redirect_pending are never both 1.
- pc_next_sel is never 11.

Test Plan:
1. Reset held 2 cycles with ex_pcsel = 1 and trap_req = 1 → all outputs 0, redirect_count = 0. First RUN cycle with no inputs active and imem_ready = 1 → pc_we = 1, pc_next_sel = 00.
2. RUN, DRAIN_CYCLES = 1, ex_valid = ex_pcsel = 1, ex_target = 0x0000_1235, imem_ready = 1:
   - same cycle → pc_redirect = 0x0000_1234, pc_next_sel = 01, pc_we = 1, both flushes = 1;
   - next cycle (DRAIN) → flush_if_id = 1 only;
   - following cycle → back in RUN; redirect_count = 1.
3. Branch to 0x2000 with imem_ready = 0 for 3 cycles → HOLD with redirect_pending = 1 and pc_we = 0 for those 3 cycles. Then imem_ready = 1 → pc_we = 1, pc_redirect = 0x2000.
4. In HOLD (branch 0x2000 held), trap_req with trap_vector = 0x8000_0000 → same cycle pc_redirect = 0x8000_0000, pc_next_sel = 10. Release imem_ready → PC written to 0x8000_0000, redirect_count +1 only.
5. Same cycle trap_req = 1, ex_pcsel = 1, ex_target = 0x100 → trap wins: pc_next_sel = 10. Separately, stall_req = 1 with no event → pc_we = 0, flush_id_ex = 1, flush_if_id = 0.
6. CNT_W = 4: 17 accepted redirects → redirect_count = 1 (wrap). DRAIN_CYCLES = 3 with imem_ready toggling 1,0,1,0,1 → DRAIN lasts exactly 5 cycles before RUN.
